// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions: opcodes, field widths, packed h2d/d2h bit offsets
// and the response entry carried through the adapter's response FIFO.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DUW = 16;
    localparam int TL_SZW = 2;

    localparam int TL_H2D_W = 102;
    localparam int TL_D2H_W = 68;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    localparam int H2D_A_VALID   = 101;
    localparam int H2D_A_OPCODE  = 98;
    localparam int H2D_A_PARAM   = 95;
    localparam int H2D_A_SIZE    = 93;
    localparam int H2D_A_SOURCE  = 85;
    localparam int H2D_A_ADDRESS = 53;
    localparam int H2D_A_MASK    = 49;
    localparam int H2D_A_DATA    = 17;
    localparam int H2D_A_USER    = 1;
    localparam int H2D_D_READY   = 0;

    localparam int D2H_D_VALID  = 67;
    localparam int D2H_D_OPCODE = 64;
    localparam int D2H_D_PARAM  = 61;
    localparam int D2H_D_SIZE   = 59;
    localparam int D2H_D_SOURCE = 51;
    localparam int D2H_D_SINK   = 50;
    localparam int D2H_D_DATA   = 18;
    localparam int D2H_D_USER   = 2;
    localparam int D2H_D_ERROR  = 1;
    localparam int D2H_A_READY  = 0;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [TL_SZW-1:0] size;
        logic [TL_AIW-1:0] source;
        logic [TL_DW-1:0]  data;
        logic              error;
    } tl_rsp_t;

    // Byte lanes a request of the given size may touch at the given word offset.
    function automatic logic [3:0] tl_lane_mask(input logic [1:0] size, input logic [1:0] addrLo);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001 << addrLo;
            2'd1:    m = addrLo[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tlul_adapter_mem_rspfifo.sv
// In-order response FIFO for tlul_adapter_mem; the head entry is read straight
// from storage flops so the d channel carries no combinational input path.
module tlul_adapter_mem_rspfifo
    import tlul_pkg::*;
#(
    parameter int Depth = 2,
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  tl_rsp_t         wdata_i,
    input  logic            pop_i,
    output logic            valid_o,
    output tl_rsp_t         rdata_o,
    output logic [CntW-1:0] count_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    tl_rsp_t         storage_q [Depth];
    logic [PtrW-1:0] wrPtr_q, wrPtr_d;
    logic [PtrW-1:0] rdPtr_q, rdPtr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            doPush, doPop;

    function automatic logic [PtrW-1:0] ptrInc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign doPop  = pop_i && (count_q != '0);
    assign doPush = push_i && ((count_q != CntW'(Depth)) || doPop);

    always_comb begin
        wrPtr_d = doPush ? ptrInc(wrPtr_q) : wrPtr_q;
        rdPtr_d = doPop ? ptrInc(rdPtr_q) : rdPtr_q;
        count_d = count_q + CntW'(doPush) - CntW'(doPop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                storage_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                storage_q[wrPtr_q] <= wdata_i;
            end
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = storage_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/tlul_adapter_mem.sv
// TL-UL device-side responder for a 1-cycle-latency single-port memory.
// Define TLUL_ADAPTER_MEM_RANGE_CHK_EN to reject addresses beyond the memory.
module tlul_adapter_mem
    import tlul_pkg::*;
#(
    parameter int MemAw       = 10,
    parameter int Outstanding = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [TL_H2D_W-1:0] tl_i,
    output logic [TL_D2H_W-1:0] tl_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [MemAw-1:0]    mem_addr_o,
    output logic [31:0]         mem_wdata_o,
    output logic [3:0]          mem_wmask_o,
    input  logic [31:0]         mem_rdata_i
);

    localparam int CntW = $clog2(Outstanding + 1);
    localparam logic [31:0] OutstandingU = Outstanding;

    logic              aValid;
    logic [2:0]        aOpcode;
    logic [TL_SZW-1:0] aSize;
    logic [TL_AIW-1:0] aSource;
    logic [TL_AW-1:0]  aAddress;
    logic [3:0]        aMask;
    logic [TL_DW-1:0]  aData;
    logic              dReady;
    logic              unusedTl;

    logic              aReady, accept, reqErr;
    logic [CntW-1:0]   fifoCount;
    logic              fifoValid, fifoPop;
    tl_rsp_t           rspIn, rspHead;

    logic              pipeValid_q, pipeValid_d;
    logic [TL_AIW-1:0] pipeSource_q, pipeSource_d;
    logic [TL_SZW-1:0] pipeSize_q, pipeSize_d;
    logic              pipeRead_q, pipeRead_d;
    logic              pipeErr_q, pipeErr_d;

    assign aValid   = tl_i[H2D_A_VALID];
    assign aOpcode  = tl_i[H2D_A_OPCODE +: 3];
    assign aSize    = tl_i[H2D_A_SIZE +: TL_SZW];
    assign aSource  = tl_i[H2D_A_SOURCE +: TL_AIW];
    assign aAddress = tl_i[H2D_A_ADDRESS +: TL_AW];
    assign aMask    = tl_i[H2D_A_MASK +: 4];
    assign aData    = tl_i[H2D_A_DATA +: TL_DW];
    assign dReady   = tl_i[H2D_D_READY];
    assign unusedTl = ^{tl_i[H2D_A_PARAM +: 3], tl_i[H2D_A_USER +: TL_DUW], aAddress[TL_AW-1:MemAw+2]};

    // Credits count the pipe stage too; a pop this cycle frees a slot only next cycle.
    assign aReady = !rst_i && ((32'(fifoCount) + 32'(pipeValid_q)) < OutstandingU);
    assign accept = aValid && aReady;

    always_comb begin
        reqErr = 1'b0;
        if (!(aOpcode == Get || aOpcode == PutFullData || aOpcode == PutPartialData)) begin
            reqErr = 1'b1;
        end
        if (aSize > 2'd2) begin
            reqErr = 1'b1;
        end
        if ((aSize == 2'd1 && aAddress[0]) || (aSize == 2'd2 && aAddress[1:0] != 2'b00)) begin
            reqErr = 1'b1;
        end
        if (aOpcode == PutFullData && aSize == 2'd2 && aMask != 4'hF) begin
            reqErr = 1'b1;
        end
        if ((aMask & ~tl_lane_mask(aSize, aAddress[1:0])) != 4'h0) begin
            reqErr = 1'b1;
        end
`ifdef TLUL_ADAPTER_MEM_RANGE_CHK_EN
        if (aAddress[TL_AW-1:MemAw+2] != '0) begin
            reqErr = 1'b1;
        end
`endif
    end

    assign mem_req_o   = accept && !reqErr;
    assign mem_we_o    = (aOpcode != Get);
    assign mem_addr_o  = aAddress[MemAw+1:2];
    assign mem_wdata_o = aData;
    assign mem_wmask_o = aMask;

    always_comb begin
        pipeValid_d  = accept;
        pipeSource_d = pipeSource_q;
        pipeSize_d   = pipeSize_q;
        pipeRead_d   = pipeRead_q;
        pipeErr_d    = pipeErr_q;
        if (accept) begin
            pipeSource_d = aSource;
            pipeSize_d   = aSize;
            pipeRead_d   = (aOpcode == Get);
            pipeErr_d    = reqErr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipeValid_q  <= 1'b0;
            pipeSource_q <= '0;
            pipeSize_q   <= '0;
            pipeRead_q   <= 1'b0;
            pipeErr_q    <= 1'b0;
        end else begin
            pipeValid_q  <= pipeValid_d;
            pipeSource_q <= pipeSource_d;
            pipeSize_q   <= pipeSize_d;
            pipeRead_q   <= pipeRead_d;
            pipeErr_q    <= pipeErr_d;
        end
    end

    // Read data arrives the cycle after the request, exactly while the pipe stage is valid.
    always_comb begin
        rspIn.opcode = pipeRead_q ? AccessAckData : AccessAck;
        rspIn.size   = pipeSize_q;
        rspIn.source = pipeSource_q;
        rspIn.error  = pipeErr_q;
        if (!pipeRead_q) begin
            rspIn.data = '0;
        end else if (pipeErr_q) begin
            rspIn.data = '1;
        end else begin
            rspIn.data = mem_rdata_i;
        end
    end

    assign fifoPop = fifoValid && dReady;

    tlul_adapter_mem_rspfifo #(
        .Depth (Outstanding)
    ) u_rspfifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pipeValid_q),
        .wdata_i (rspIn),
        .pop_i   (fifoPop),
        .valid_o (fifoValid),
        .rdata_o (rspHead),
        .count_o (fifoCount)
    );

    always_comb begin
        tl_o = '0;
        tl_o[D2H_A_READY] = aReady;
        if (fifoValid) begin
            tl_o[D2H_D_VALID]              = 1'b1;
            tl_o[D2H_D_OPCODE +: 3]        = rspHead.opcode;
            tl_o[D2H_D_SIZE +: TL_SZW]     = rspHead.size;
            tl_o[D2H_D_SOURCE +: TL_AIW]   = rspHead.source;
            tl_o[D2H_D_DATA +: TL_DW]      = rspHead.data;
            tl_o[D2H_D_ERROR]              = rspHead.error;
        end
    end

endmodule

// File: tb/tb_tlul_adapter_mem.sv
// Directed bench for tlul_adapter_mem: a default instance (Outstanding=2) plus a
// deeper instance (Outstanding=3) for the one-accept-per-cycle stream.
module tb_tlul_adapter_mem;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        aValid;
    logic [2:0]  aOpcode;
    logic [1:0]  aSize;
    logic [7:0]  aSource;
    logic [31:0] aAddress;
    logic [3:0]  aMask;
    logic [31:0] aData;
    logic        dReady;

    logic [101:0] tlI;
    logic [67:0]  tlO, tlO2;
    logic         memReq, memWe, memReq2, memWe2;
    logic [9:0]   memAddr, memAddr2;
    logic [31:0]  memWdata, memRdata, memRdata2, unusedWdata2;
    logic [3:0]   memWmask, unusedWmask2;
    logic [31:0]  memArr [0:1023];

    logic dValid, aReady, dValid2, aReady2;

    int checks = 0;
    int errors = 0;

    assign tlI = {aValid, aOpcode, 3'b000, aSize, aSource, aAddress, aMask, aData, 16'h0000, dReady};
    assign dValid  = tlO[67];
    assign aReady  = tlO[0];
    assign dValid2 = tlO2[67];
    assign aReady2 = tlO2[0];

    tlul_adapter_mem #(.MemAw(10), .Outstanding(2)) dut (
        .clk_i(clk), .rst_i(rst), .tl_i(tlI), .tl_o(tlO),
        .mem_req_o(memReq), .mem_we_o(memWe), .mem_addr_o(memAddr),
        .mem_wdata_o(memWdata), .mem_wmask_o(memWmask), .mem_rdata_i(memRdata)
    );

    tlul_adapter_mem #(.MemAw(10), .Outstanding(3)) dutDeep (
        .clk_i(clk), .rst_i(rst), .tl_i(tlI), .tl_o(tlO2),
        .mem_req_o(memReq2), .mem_we_o(memWe2), .mem_addr_o(memAddr2),
        .mem_wdata_o(unusedWdata2), .mem_wmask_o(unusedWmask2), .mem_rdata_i(memRdata2)
    );

    // Behavioural memory: word i resets to 0x1000_0000+i; only the main instance writes.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) begin
                memArr[i] <= 32'h1000_0000 + 32'(i);
            end
        end else if (memReq && memWe) begin
            for (int b = 0; b < 4; b++) begin
                if (memWmask[b]) memArr[memAddr][8*b +: 8] <= memWdata[8*b +: 8];
            end
        end
        if (memReq && !memWe) memRdata <= memArr[memAddr];
        if (memReq2 && !memWe2) memRdata2 <= memArr[memAddr2];
    end

    task automatic checkOutput(input string tag, input logic [67:0] observed, input logic [67:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [1:0] size,
                                 input logic [7:0] src, input logic [31:0] addr,
                                 input logic [3:0] mask, input logic [31:0] data);
        aValid   = v;
        aOpcode  = op;
        aSize    = size;
        aSource  = src;
        aAddress = addr;
        aMask    = mask;
        aData    = data;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRsp(input string tag, input logic [67:0] obs, input logic [2:0] expOp,
                            input logic [1:0] expSize, input logic [7:0] expSrc,
                            input logic [31:0] expData, input logic expErr);
        checkOutput({tag, "_d_valid"},  68'(obs[67]), 68'd1);
        checkOutput({tag, "_d_opcode"}, 68'(obs[66:64]), 68'(expOp));
        checkOutput({tag, "_d_size"},   68'(obs[60:59]), 68'(expSize));
        checkOutput({tag, "_d_source"}, 68'(obs[58:51]), 68'(expSrc));
        checkOutput({tag, "_d_data"},   68'(obs[49:18]), 68'(expData));
        checkOutput({tag, "_d_error"},  68'(obs[1]), 68'(expErr));
        checkOutput({tag, "_d_fixed"},  68'({obs[63:61], obs[50], obs[17:2]}), 68'd0);
    endtask

    // One isolated transaction on the main instance with d_ready held high.
    task automatic doReq(input string tag, input logic [2:0] op, input logic [1:0] size,
                         input logic [7:0] src, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic expReq, input logic [2:0] expOp,
                         input logic [31:0] expData, input logic expErr);
        applyStimulus(1'b1, op, size, src, addr, mask, data);
        @(negedge clk);
        checkOutput({tag, "_a_ready"}, 68'(aReady), 68'd1);
        checkOutput({tag, "_mem_req"}, 68'(memReq), 68'(expReq));
        if (expReq) begin
            checkOutput({tag, "_mem_addr"}, 68'(memAddr), 68'(addr[11:2]));
            checkOutput({tag, "_mem_we"}, 68'(memWe), 68'(op != 3'd4));
        end
        nextCycle();
        applyStimulus(1'b0, 3'd4, 2'd2, 8'h00, 32'h0, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput({tag, "_early"}, 68'(dValid), 68'd0);
        nextCycle();
        @(negedge clk);
        checkRsp(tag, tlO, expOp, size, src, expData, expErr);
        nextCycle();
    endtask

    initial begin
        rst    = 1'b1;
        dReady = 1'b1;
        applyStimulus(1'b1, 3'd4, 2'd2, 8'h01, 32'h0, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_tl_o", 68'(tlO), 68'd0);
            checkOutput("rst_mem_req", 68'(memReq), 68'd0);
        end
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 3'd4, 2'd2, 8'h00, 32'h0, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_rst_d_valid", 68'(dValid), 68'd0);
            checkOutput("post_rst_a_ready", 68'(aReady), 68'd1);
            nextCycle();
        end

        doReq("put_full", 3'd0, 2'd2, 8'h05, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b1, 3'd0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("put_full_wdata", 68'(memArr[4]), 68'h0_DEAD_BEEF);
        nextCycle();
        doReq("get_after_put", 3'd4, 2'd2, 8'h06, 32'h10, 4'hF, 32'h0, 1'b1, 3'd1, 32'hDEAD_BEEF, 1'b0);
        doReq("get_misaligned", 3'd4, 2'd2, 8'h07, 32'h2, 4'hF, 32'h0, 1'b0, 3'd1, 32'hFFFF_FFFF, 1'b1);
        doReq("bad_opcode", 3'd3, 2'd2, 8'h08, 32'h0, 4'hF, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1);
        doReq("partial_bad_mask", 3'd1, 2'd0, 8'h09, 32'h11, 4'b0001, 32'h55, 1'b0, 3'd0, 32'h0, 1'b1);
        doReq("putfull_short_mask", 3'd0, 2'd2, 8'h0C, 32'h10, 4'b0011, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1);
        doReq("partial_byte", 3'd1, 2'd0, 8'h0A, 32'h13, 4'b1000, 32'h7700_0000, 1'b1, 3'd0, 32'h0, 1'b0);
        doReq("get_merged", 3'd4, 2'd2, 8'h0B, 32'h10, 4'hF, 32'h0, 1'b1, 3'd1, 32'h77AD_BEEF, 1'b0);
        doReq("get_half", 3'd4, 2'd1, 8'h0D, 32'h12, 4'b1100, 32'h0, 1'b1, 3'd1, 32'h77AD_BEEF, 1'b0);

        // Backpressure: two credits fill up, then the stalled Get waits for a freed slot.
        dReady = 1'b0;
        applyStimulus(1'b1, 3'd4, 2'd2, 8'h10, 32'h0, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("bp_acc0_ready", 68'(aReady), 68'd1);
        nextCycle();
        applyStimulus(1'b1, 3'd4, 2'd2, 8'h11, 32'h4, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("bp_acc1_ready", 68'(aReady), 68'd1);
        nextCycle();
        applyStimulus(1'b1, 3'd4, 2'd2, 8'h12, 32'h8, 4'hF, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("bp_stall_ready", 68'(aReady), 68'd0);
            checkOutput("bp_stall_req", 68'(memReq), 68'd0);
            checkRsp("bp_hold", tlO, 3'd1, 2'd2, 8'h10, 32'h1000_0000, 1'b0);
            nextCycle();
        end
        dReady = 1'b1;
        @(negedge clk);
        checkOutput("bp_no_credit", 68'(aReady), 68'd0);
        checkRsp("bp_rsp0", tlO, 3'd1, 2'd2, 8'h10, 32'h1000_0000, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("bp_resume_ready", 68'(aReady), 68'd1);
        checkRsp("bp_rsp1", tlO, 3'd1, 2'd2, 8'h11, 32'h1000_0001, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 3'd4, 2'd2, 8'h13, 32'hC, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("bp_acc3_ready", 68'(aReady), 68'd1);
        checkOutput("bp_gap", 68'(dValid), 68'd0);
        nextCycle();
        applyStimulus(1'b0, 3'd4, 2'd2, 8'h00, 32'h0, 4'hF, 32'h0);
        @(negedge clk);
        checkRsp("bp_rsp2", tlO, 3'd1, 2'd2, 8'h12, 32'h1000_0002, 1'b0);
        nextCycle();
        @(negedge clk);
        checkRsp("bp_rsp3", tlO, 3'd1, 2'd2, 8'h13, 32'h1000_0003, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("bp_drained", 68'(dValid), 68'd0);
        nextCycle();

        // Reset with a response pending: nothing may come out afterwards.
        dReady = 1'b0;
        applyStimulus(1'b1, 3'd4, 2'd2, 8'h30, 32'h0, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("mid_req", 68'(memReq), 68'd1);
        nextCycle();
        applyStimulus(1'b0, 3'd4, 2'd2, 8'h00, 32'h0, 4'hF, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("mid_pending", 68'(dValid), 68'd1);
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_ready", 68'(aReady), 68'd0);
        nextCycle();
        rst    = 1'b0;
        dReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("mid_no_rsp", 68'(dValid), 68'd0);
            checkOutput("mid_no_rsp_deep", 68'(dValid2), 68'd0);
            nextCycle();
        end

        // Back-to-back stream on the deeper instance: one accept per cycle, first response two cycles later.
        for (int c = 0; c < 10; c++) begin
            if (c < 8) applyStimulus(1'b1, 3'd4, 2'd2, 8'(8'h20 + c), 32'(4 * c), 4'hF, 32'h0);
            else       applyStimulus(1'b0, 3'd4, 2'd2, 8'h00, 32'h0, 4'hF, 32'h0);
            @(negedge clk);
            if (c < 8) begin
                checkOutput("tp_ready", 68'(aReady2), 68'd1);
                checkOutput("tp_req", 68'(memReq2), 68'd1);
            end
            if (c < 2) checkOutput("tp_latency", 68'(dValid2), 68'd0);
            else       checkRsp("tp_rsp", tlO2, 3'd1, 2'd2, 8'(8'h20 + c - 2), 32'h1000_0000 + 32'(c - 2), 1'b0);
            nextCycle();
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("tp_drained", 68'(dValid2), 68'd0);
            nextCycle();
        end

`ifdef TLUL_ADAPTER_MEM_RANGE_CHK_EN
        doReq("range_chk", 3'd4, 2'd2, 8'h40, 32'h1000, 4'hF, 32'h0, 1'b0, 3'd1, 32'hFFFF_FFFF, 1'b1);
`else
        doReq("range_alias", 3'd4, 2'd2, 8'h40, 32'h1000, 4'hF, 32'h0, 1'b1, 3'd1, 32'h1000_0000, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
